// File: rtl/inst_queue.sv
// Dual-lane first-word-fall-through instruction queue between fetch and decode.
// Define INST_QUEUE_PERF_CNT_EN to add the full/empty stall counters.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [31:0]      in_pc0,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_inst1,
  output logic             in_ready,
  output logic [1:0]       out_valid,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_inst0,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst1,
  input  logic [1:0]       out_accept,
  output logic [PTR_W:0]   count
`ifdef INST_QUEUE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_full_cycles,
  output logic [31:0]      perf_empty_cycles
`endif
);

  localparam int CW = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [CW-1:0]    count_q, count_d;
  logic             push0, push1, pop0, pop1;

  // Ready looks only at registered occupancy: a same-cycle pop never frees room for a push.
  assign in_ready  = (count_q <= CW'(DEPTH - 2));
  assign out_valid = {count_q >= CW'(2), count_q != '0};
  assign count     = count_q;
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

  assign out_pc0   = out_valid[0] ? mem_q[rd_ptr_q].pc    : '0;
  assign out_inst0 = out_valid[0] ? mem_q[rd_ptr_q].inst  : '0;
  assign out_pc1   = out_valid[1] ? mem_q[rd_ptr_p1].pc   : '0;
  assign out_inst1 = out_valid[1] ? mem_q[rd_ptr_p1].inst : '0;

  always_comb begin
    push0    = in_valid[0] && in_ready && !flush;
    push1    = push0 && in_valid[1];
    pop0     = out_accept[0] && out_valid[0];
    pop1     = pop0 && out_accept[1] && out_valid[1];
    wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop0) + PTR_W'(pop1);
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop0) - CW'(pop1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr_q]  <= '{pc: in_pc0, inst: in_inst0};
    if (push1) mem_q[wr_ptr_p1] <= '{pc: in_pc1, inst: in_inst1};
  end

`ifdef INST_QUEUE_PERF_CNT_EN
  logic [31:0] perf_full_q, perf_empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      if (in_valid[0] && !in_ready && perf_full_q != '1)
        perf_full_q <= perf_full_q + 32'd1;
      if (count_q == '0 && perf_empty_q != '1)
        perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign perf_full_cycles  = perf_full_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed and randomized bench for inst_queue, checked against a queue-based reference model.
module tb_inst_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  in_valid, out_accept;
  logic [31:0] in_pc0, in_inst0, in_pc1, in_inst1;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
  logic [PTR_W:0] count;
`ifdef INST_QUEUE_PERF_CNT_EN
  logic [31:0] perf_full_cycles, perf_empty_cycles;
`endif

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_pc0(in_pc0), .in_inst0(in_inst0), .in_pc1(in_pc1), .in_inst1(in_inst1),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_pc0(out_pc0), .out_inst0(out_inst0), .out_pc1(out_pc1), .out_inst1(out_inst1),
    .out_accept(out_accept), .count(count)
`ifdef INST_QUEUE_PERF_CNT_EN
    , .perf_full_cycles(perf_full_cycles), .perf_empty_cycles(perf_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a plain FIFO of {pc, inst} words plus two stall counters.
  logic [63:0] mq[$];
  bit          model_ok = 0;
  logic [31:0] m_full = 0, m_empty = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int sz = mq.size();
    logic [63:0] e0 = (sz >= 1) ? mq[0] : 64'd0;
    logic [63:0] e1 = (sz >= 2) ? mq[1] : 64'd0;
    chk("count",     64'(count), 64'(sz));
    chk("in_ready",  64'(in_ready), 64'(sz <= DEPTH - 2));
    chk("out_valid", 64'(out_valid), {62'd0, sz >= 2, sz >= 1});
    chk("head0",     {out_pc0, out_inst0}, e0);
    chk("head1",     {out_pc1, out_inst1}, e1);
`ifdef INST_QUEUE_PERF_CNT_EN
    chk("perf_full",  64'(perf_full_cycles), 64'(m_full));
    chk("perf_empty", 64'(perf_empty_cycles), 64'(m_empty));
`endif
  endtask

  task automatic model_step();
    int sz = mq.size();
    bit ready = (sz <= DEPTH - 2);
    int npop = 0;
    if (rst) begin
      mq.delete();
      m_full = 0;
      m_empty = 0;
      model_ok = 1;
      return;
    end
    if (in_valid[0] && !ready && m_full != 32'hFFFF_FFFF) m_full++;
    if (sz == 0 && m_empty != 32'hFFFF_FFFF) m_empty++;
    if (flush) begin
      mq.delete();
      return;
    end
    if (out_accept[0] && sz >= 1) npop = (out_accept[1] && sz >= 2) ? 2 : 1;
    for (int k = 0; k < npop; k++) void'(mq.pop_front());
    if (in_valid[0] && ready) begin
      mq.push_back({in_pc0, in_inst0});
      if (in_valid[1]) mq.push_back({in_pc1, in_inst1});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (model_ok) chk_state();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                       input logic [31:0] p1, input logic [31:0] i1,
                       input logic [1:0] acc, input logic fl);
    in_valid = v; in_pc0 = p0; in_inst0 = i0; in_pc1 = p1; in_inst1 = i1;
    out_accept = acc; flush = fl;
  endtask

  task automatic idle();
    drive(2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
  endtask

  initial begin
    logic [31:0] pc, head, snap;
    rst = 1'b1;
    idle();
    cycle();
    cycle();
    rst = 1'b0;

    // Reset then idle
    repeat (3) cycle();
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_pc0", 64'(out_pc0), 64'd0);

    // First dual push
    drive(2'b11, 32'h1c000000, 32'h02800421, 32'h1c000004, 32'h03400000, 2'b00, 1'b0);
    cycle();
    idle();
    chk("pp_valid", 64'(out_valid), 64'd3);
    chk("pp_pc0", 64'(out_pc0), 64'h1c000000);
    chk("pp_inst1", 64'(out_inst1), 64'h03400000);
    chk("pp_count", 64'(count), 64'd2);
    cycle();

    // Fill to DEPTH, stall, then drain one per cycle
    rst = 1'b1; cycle(); rst = 1'b0;
    pc = 32'h1c001000;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, pc, $urandom(), pc + 4, $urandom(), 2'b00, 1'b0);
      cycle();
      pc += 8;
      if (k == 2) chk("fill6_ready", 64'(in_ready), 64'd1);
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'hdead0000, 0, 32'hdead0004, 0, 2'b00, 1'b0);
      cycle();
    end
    chk("drop_count", 64'(count), 64'd8);
`ifdef INST_QUEUE_PERF_CNT_EN
    chk("perf_full3", 64'(perf_full_cycles), 64'd3);
`endif
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 0, 0, 0, 0, 2'b01, 1'b0);
      chk("drain_pc", 64'(out_pc0), 64'(32'h1c001000 + 32'(4 * k)));
      cycle();
      if (k == 0) chk("count7_ready", 64'(in_ready), 64'd0);
    end

    // Steady dual push / dual pop across the wrap
    idle(); flush = 1'b1; cycle();
    pc = 32'h1c002000;
    head = pc;
    drive(2'b11, pc, $urandom(), pc + 4, $urandom(), 2'b00, 1'b0);
    cycle();
    pc += 8;
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, pc, $urandom(), pc + 4, $urandom(), 2'b11, 1'b0);
      chk("steady_pc0", 64'(out_pc0), 64'(head));
      chk("steady_pc1", 64'(out_pc1), 64'(head + 4));
      cycle();
      pc += 8;
      head += 8;
    end
    chk("steady_count", 64'(count), 64'd2);

    // Flush at count=5 with concurrent push and pop
    idle(); flush = 1'b1; cycle();
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, pc, $urandom(), pc + 4, $urandom(), 2'b00, 1'b0);
      cycle();
      pc += 8;
    end
    drive(2'b01, pc, $urandom(), 0, 0, 2'b00, 1'b0);
    cycle();
    pc += 4;
    chk("pre_flush_count", 64'(count), 64'd5);
    drive(2'b11, pc, $urandom(), pc + 4, $urandom(), 2'b11, 1'b1);
    cycle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    drive(2'b01, 32'h1c00beef, 32'h00000001, 0, 0, 2'b00, 1'b0);
    cycle();
    chk("post_flush_head", 64'(out_pc0), 64'h1c00beef);

    // Lane1-only requests are ignored
    drive(2'b01, 32'h1c00c000, 32'h2, 0, 0, 2'b00, 1'b0);
    cycle();
    snap = out_pc0;
    drive(2'b10, 32'h1c00d000, 32'h3, 32'h1c00d004, 32'h4, 2'b10, 1'b0);
    cycle();
    chk("lane1_count", 64'(count), 64'd2);
    chk("lane1_head", 64'(out_pc0), 64'(snap));

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom(), $urandom(),
            2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0));
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
